// File: rtl/bus_arbiter_pkg.sv
// Shared bus-level encodings: arbiter FSM states and master-select values.
// Master-select constants are also used by command_processor.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M1 = 2'd1,
    OWN_M2 = 2'd2,
    TURN   = 2'd3
  } arb_state_t;

  localparam logic MSEL_M1 = 1'b1;
  localparam logic MSEL_M2 = 1'b0;

endpackage

// File: rtl/bus_arbiter_watchdog.sv
// Ownership watchdog: counts cycles while a master owns the bus.
// Flags expiry on the last allowed cycle so the count never wraps.
module arb_watchdog #(
  parameter int TIMEOUT_LEN = 10,
  parameter int TIMEOUT     = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic expire
);

  localparam logic [TIMEOUT_LEN-1:0] LAST =
    TIMEOUT_LEN'(TIMEOUT - 1);

  logic [TIMEOUT_LEN-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || !run) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign expire = run && (count == LAST);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter with fixed or round-robin priority,
// release on done/abort/watchdog, and a one-cycle turnaround.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_LEN = 10,
  parameter int TIMEOUT     = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic req_m1,
  input  logic req_m2,
  input  logic prio_mode,
  input  logic tx_done,
  input  logic rx_done,
  output logic grant_m1,
  output logic grant_m2,
  output logic master_select,
  output logic timeout,
  output logic last_owner
);

  arb_state_t state, state_nxt;
  logic g1_nxt, g2_nxt, ms_nxt;
  logic to_nxt, lo_nxt;
  logic owning, done, abort;
  logic expire, release_bus;

  assign owning = (state == OWN_M1) || (state == OWN_M2);
  assign done   = tx_done || rx_done;
  assign abort  = ((state == OWN_M1) && !req_m1)
               || ((state == OWN_M2) && !req_m2);
  assign release_bus = owning && (done || abort || expire);

  arb_watchdog #(
    .TIMEOUT_LEN(TIMEOUT_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .run   (owning),
    .clear (release_bus),
    .expire(expire)
  );

  always_comb begin
    state_nxt = state;
    g1_nxt    = 1'b0;
    g2_nxt    = 1'b0;
    ms_nxt    = MSEL_M2;
    to_nxt    = 1'b0;
    lo_nxt    = last_owner;
    unique case (state)
      IDLE: begin
        // m2 wins a tie only in round-robin when m1 went last
        if (req_m1 && (!req_m2 || !prio_mode || !last_owner)) begin
          state_nxt = OWN_M1;
          g1_nxt    = 1'b1;
          ms_nxt    = MSEL_M1;
        end else if (req_m2) begin
          state_nxt = OWN_M2;
          g2_nxt    = 1'b1;
        end
      end
      OWN_M1: begin
        if (release_bus) begin
          state_nxt = TURN;
          lo_nxt    = 1'b1;
          to_nxt    = expire && !done;
        end else begin
          g1_nxt = 1'b1;
          ms_nxt = MSEL_M1;
        end
      end
      OWN_M2: begin
        if (release_bus) begin
          state_nxt = TURN;
          lo_nxt    = 1'b0;
          to_nxt    = expire && !done;
        end else begin
          g2_nxt = 1'b1;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant_m1      <= 1'b0;
      grant_m2      <= 1'b0;
      master_select <= 1'b0;
      timeout       <= 1'b0;
      last_owner    <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant_m1      <= g1_nxt;
      grant_m2      <= g2_nxt;
      master_select <= ms_nxt;
      timeout       <= to_nxt;
      last_owner    <= lo_nxt;
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter for the shared system bus. It takes transaction requests from master 1 and master 2 and grants bus ownership to exactly one of them at a time. Ownership is held until the bus signals completion, the owner withdraws its request, or a watchdog timeout fires. It sits between the master-side command logic and the `bus` instance, and drives the grant and master-select lines that steer the bus muxes.

## Interface
Parameters:
- `TIMEOUT_LEN`, default 10: width of the watchdog counter.
- `TIMEOUT`, default 1000: cycles an owner may hold the bus before a forced release; legal range 2..2^TIMEOUT_LEN-1.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `req_m1`  in  1  master 1 requests the bus; level, held until done.
- `req_m2`  in  1  master 2 requests the bus; level, held until done.
- `prio_mode`  in  1  0 = fixed priority (m1 wins ties), 1 = round-robin.
- `tx_done`  in  1  bus write-complete pulse for the current owner.
- `rx_done`  in  1  bus read-complete pulse for the current owner.
- `grant_m1`  out  1  master 1 owns the bus.
- `grant_m2`  out  1  master 2 owns the bus.
- `master_select`  out  1  1 = m1 drives the bus, 0 = m2; valid while a grant is high.
- `timeout`  out  1  one-cycle pulse on watchdog release.
- `last_owner`  out  1  1 = m1 was the most recent owner; round-robin history.

## Operation
- FSM states: `IDLE`, `OWN_M1`, `OWN_M2`, `TURN`. All outputs are registered.
- Reset values: state `IDLE`, grants 0, `master_select` 0, `timeout` 0, `last_owner` 0, watchdog counter 0.
- `IDLE`:
  - Neither request → stay in `IDLE`.
  - Only one request → go to that master's `OWN_x`.
  - Both requests with `prio_mode`=0 → `OWN_M1`.
  - Both requests with `prio_mode`=1 → grant the master that is not `last_owner`.
- `OWN_x`:
  - `grant_x`=1; `master_select` = (x==m1).
  - Watchdog increments each cycle from 0.
- Release from `OWN_x` to `TURN` on any of:
  - (a) `tx_done` or `rx_done` = 1;
  - (b) `req_x` = 0 (owner abort);
  - (c) watchdog == `TIMEOUT`-1, which also pulses `timeout`.
  - If (a) and (c) coincide, the transaction counts as completed and `timeout` stays 0.
- On release: `last_owner` ← x, grants cleared, watchdog cleared.
- `TURN`: one idle bus cycle with no grant, then unconditionally `IDLE`.
- `prio_mode` is sampled only in `IDLE`. A change mid-ownership has no effect on the current owner.
- The non-owner's request is ignored while another master owns the bus; it is never dropped, and is served on a later `IDLE` evaluation.
- Done pulses arriving in `IDLE` or `TURN` are ignored.
- Invariant: `grant_m1` & `grant_m2` is never 1.

## Timing
- Grant latency: request sampled at edge N in `IDLE` → grant high after edge N, visible in cycle N+1.
- Done at edge M → grant low in cycle M+1 (`TURN`) → `IDLE` in M+2 → next grant earliest in M+3.
- Minimum gap between two grants is two grant-free cycles.
- A timeout release happens `TIMEOUT` cycles after the grant rises. `timeout` is high for exactly the first `TURN` cycle.
- Reset asserted in any state, including mid-ownership: at the next edge all outputs take their reset values. A pending done is discarded.
- The watchdog never wraps; it is bounded by `TIMEOUT`-1.

## Structure
- The bus-level package holds:
  - the FSM state encoding, 2 bits (`IDLE`=0, `OWN_M1`=1, `OWN_M2`=2, `TURN`=3);
  - the `master_select` encoding constants (M1=1, M2=0), shared with `command_processor`.
- One natural sub-module: `arb_watchdog` (counter, clear, expire flag, parameterised by `TIMEOUT_LEN`/`TIMEOUT`).
- Tie-break and round-robin logic stay inline in the FSM.

## Test plan
- Reset, then `req_m1`=1 only → `grant_m1`=1 and `master_select`=1 in the next cycle. `tx_done` pulse → `grant_m1`=0 the following cycle, `last_owner`=1.
- `prio_mode`=0, both requests held across 3 transactions → grants go m1, m1, m1; `grant_m2` never asserts.
- `prio_mode`=1, both requests held, 4 transactions completed with `rx_done` → grants alternate m1, m2, m1, m2, each separated by 2 grant-free cycles.
- `TIMEOUT`=8, `req_m2` held with no done → `grant_m2` high for exactly 8 cycles, then `timeout`=1 for 1 cycle, then a regrant of m2 3 cycles after release.
- `tx_done` and watchdog expiry in the same cycle → release with `timeout`=0. Separately, `req_m1` dropped mid-ownership → release next cycle, `timeout`=0.
- `reset` pulsed while in `OWN_M2` with `req_m1` pending → all outputs 0 next cycle; after reset drops, `grant_m1` rises 1 cycle later.
